mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port main memory between the CPU core (port 0) and the UART program loader/debug port (port 1). It sequences one memory access at a time through a 3-state FSM and applies round-robin priority on contention. It owns the memory's address, write-enable and data-in lines and returns read data with a valid strobe.

---
 rtl/mem_arbiter_if.sv | 59 +++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports, memory bus and busy flag of the two-port
// memory arbiter. The slave modport is the arbiter's view; the master modport
// is the view of the requesters and the memory.
// Build option: MEM_ARB_LOCK_EN adds the r1_lock signal.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic                  r0_req;
    logic                  r0_we;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_ack;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_req;
    logic                  r1_we;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_ack;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic                  r1_lock;
`endif

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  busy;

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  r1_lock,
`endif
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_ack, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_ack, r1_rvalid, r1_rdata,
        output mem_addr, mem_write_enable, mem_data_in,
        input  mem_data_out,
        output busy
    );

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output r1_lock,
`endif
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_ack, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_ack, r1_rvalid, r1_rdata,
        input  mem_addr, mem_write_enable, mem_data_in,
        output mem_data_out,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU core (port 0)
// and the UART loader/debug port (port 1). One access at a time through an
// IDLE/ISSUE/WAIT sequence, round-robin on contention, all outputs registered.
// Build option: MEM_ARB_LOCK_EN lets the loader hold the memory with r1_lock.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 255
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // One extra bit so a DEPTH of 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [1:0]            r_state;
    logic                  r_last_grant;
    logic                  r_winner;
    logic                  r_is_read;
    logic                  r_in_range;
    logic                  r_ack0, r_ack1;
    logic                  r_rvalid0, r_rvalid1;
    logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
    logic                  r_we;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_req0, w_req1;
    logic                  w_grant;
    logic                  w_sel;
    logic                  w_we;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Pick the winner among the live requests; only consumed in IDLE.
    always_comb begin
        w_req0 = bus.r0_req;
`ifdef MEM_ARB_LOCK_EN
        // Loader keeps the memory while it holds the lock and owns last grant.
        if (bus.r1_lock && r_last_grant) begin
            w_req0 = 1'b0;
        end
`endif
        w_req1     = bus.r1_req;
        w_grant    = w_req0 | w_req1;
        w_sel      = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
        w_we       = w_sel ? bus.r1_we    : bus.r0_we;
        w_addr     = w_sel ? bus.r1_addr  : bus.r0_addr;
        w_wdata    = w_sel ? bus.r1_wdata : bus.r0_wdata;
        w_in_range = ({1'b0, w_addr} < DEPTH_W);
    end

    // Access sequencer: grant in IDLE, strobe memory in ISSUE, return read data in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_winner     <= 1'b0;
            r_is_read    <= 1'b0;
            r_in_range   <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_we      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_addr       <= w_addr;
                        r_wdata      <= w_wdata;
                        r_we         <= w_we & w_in_range;
                        r_ack0       <= ~w_sel;
                        r_ack1       <= w_sel;
                        r_last_grant <= w_sel;
                        r_winner     <= w_sel;
                        r_is_read    <= ~w_we;
                        r_in_range   <= w_in_range;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_is_read) begin
                        r_state <= S_WAIT;
                        if (r_winner) begin
                            r_rvalid1 <= 1'b1;
                            r_rdata1  <= r_in_range ? bus.mem_data_out : '0;
                        end else begin
                            r_rvalid0 <= 1'b1;
                            r_rdata0  <= r_in_range ? bus.mem_data_out : '0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r0_ack           = r_ack0;
    assign bus.r0_rvalid        = r_rvalid0;
    assign bus.r0_rdata         = r_rdata0;
    assign bus.r1_ack           = r_ack1;
    assign bus.r1_rvalid        = r_rvalid1;
    assign bus.r1_rdata         = r_rdata1;
    assign bus.mem_addr         = r_addr;
    assign bus.mem_write_enable = r_we;
    assign bus.mem_data_in      = r_wdata;
    assign bus.busy             = r_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized transactions for
// mem_arbiter, checked against a transaction-level model (expected memory
// contents and round-robin grant order). MEM_ARB_LOCK_EN enables the lock test.
module tb_mem_arbiter;
    localparam int AW    = 12;
    localparam int DW    = 12;
    localparam int DEPTH = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // Memory: asynchronous read, synchronous write; out-of-range reads return all ones.
    logic [DW-1:0] env_mem [0:(1<<AW)-1] = '{default: '0};
    assign ifc.mem_data_out = (int'(ifc.mem_addr) < DEPTH) ? env_mem[ifc.mem_addr] : '1;
    always @(posedge clk) begin
        if (ifc.mem_write_enable) env_mem[ifc.mem_addr] <= ifc.mem_data_in;
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
    bit            exp_last;

    // Current transaction
    bit            t_en [2];
    bit            t_we [2];
    logic [AW-1:0] t_a  [2];
    logic [DW-1:0] t_d  [2];

    // Observed
    int            ack_c [2], rv_c [2], ack_n [2], rv_n [2], we_n;
    logic [DW-1:0] rd [2];

    // Expected
    int            e_ack [2], e_rv [2], e_we;
    logic [DW-1:0] e_rd [2];

    int n_pass = 0;
    int n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input int p, input bit en, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_en[p] = en; t_we[p] = we; t_a[p] = a; t_d[p] = d;
    endtask

    // Grant order and results from the arbitration rules.
    task automatic model_txn();
        int order[$];
        int t;
        for (int p = 0; p < 2; p++) begin e_ack[p] = -1; e_rv[p] = -1; e_rd[p] = '0; end
        e_we = 0;
        if (t_en[0] && t_en[1]) begin
            if (exp_last) order = '{0, 1}; else order = '{1, 0};
        end else if (t_en[0]) order = '{0};
        else if (t_en[1]) order = '{1};
        t = 1;
        foreach (order[i]) begin
            int p;
            p = order[i];
            e_ack[p] = t;
            if (t_we[p]) begin
                if (int'(t_a[p]) < DEPTH) begin ref_mem[t_a[p]] = t_d[p]; e_we++; end
                t += 2;
            end else begin
                e_rv[p] = t + 1;
                e_rd[p] = (int'(t_a[p]) < DEPTH) ? ref_mem[t_a[p]] : '0;
                t += 3;
            end
            exp_last = (p == 1);
        end
    endtask

    // Present the transaction; each requester drops req once acked.
    task automatic drive(input int ncyc);
        for (int p = 0; p < 2; p++) begin ack_c[p] = -1; rv_c[p] = -1; ack_n[p] = 0; rv_n[p] = 0; rd[p] = '0; end
        we_n = 0;
        ifc.r0_req = t_en[0]; ifc.r0_we = t_we[0]; ifc.r0_addr = t_a[0]; ifc.r0_wdata = t_d[0];
        ifc.r1_req = t_en[1]; ifc.r1_we = t_we[1]; ifc.r1_addr = t_a[1]; ifc.r1_wdata = t_d[1];
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (ifc.mem_write_enable) we_n++;
            if (ifc.r0_ack) begin ack_n[0]++; if (ack_c[0] < 0) ack_c[0] = c; ifc.r0_req = 1'b0; end
            if (ifc.r1_ack) begin ack_n[1]++; if (ack_c[1] < 0) ack_c[1] = c; ifc.r1_req = 1'b0; end
            if (ifc.r0_rvalid) begin rv_n[0]++; if (rv_c[0] < 0) begin rv_c[0] = c; rd[0] = ifc.r0_rdata; end end
            if (ifc.r1_rvalid) begin rv_n[1]++; if (rv_c[1] < 0) begin rv_c[1] = c; rd[1] = ifc.r1_rdata; end end
        end
        ifc.r0_req = 1'b0;
        ifc.r1_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_total++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ifc.busy); else n_pass++;
        n_total++; if (ifc.mem_write_enable !== 1'b0) $display("FAIL reset_we: got %b expected 0", ifc.mem_write_enable); else n_pass++;
        n_total++; if (ifc.mem_addr !== 12'h000) $display("FAIL reset_addr: got %h expected 000", ifc.mem_addr); else n_pass++;
        n_total++; if (ifc.mem_data_in !== 12'h000) $display("FAIL reset_din: got %h expected 000", ifc.mem_data_in); else n_pass++;
        n_total++; if ({ifc.r0_ack, ifc.r1_ack, ifc.r0_rvalid, ifc.r1_rvalid} !== 4'b0000)
            $display("FAIL reset_strobes: got %b expected 0000", {ifc.r0_ack, ifc.r1_ack, ifc.r0_rvalid, ifc.r1_rvalid}); else n_pass++;
        n_total++; if ({ifc.r0_rdata, ifc.r1_rdata} !== 24'h0) $display("FAIL reset_rdata: got %h expected 000000", {ifc.r0_rdata, ifc.r1_rdata}); else n_pass++;
        reset = 1'b0;
        exp_last = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        // First tie after reset: port 0 first, port 1 on the following IDLE.
        set_txn(0, 1, 0, 12'h020, 12'h000); set_txn(1, 1, 0, 12'h030, 12'h000);
        model_txn(); drive(8);
        n_total++; if (ack_c[0] !== 1) $display("FAIL tie1_ack0: got cycle %0d expected 1", ack_c[0]); else n_pass++;
        n_total++; if (ack_c[1] !== 4) $display("FAIL tie1_ack1: got cycle %0d expected 4", ack_c[1]); else n_pass++;
        n_total++; if (rv_c[1] !== e_rv[1]) $display("FAIL tie1_rv1: got cycle %0d expected %0d", rv_c[1], e_rv[1]); else n_pass++;
        // A lone core access hands the next tie to port 1.
        set_txn(0, 1, 0, 12'h020, 12'h000); set_txn(1, 0, 0, 12'h000, 12'h000);
        model_txn(); drive(8);
        n_total++; if (ack_c[0] !== 1) $display("FAIL single_ack0: got cycle %0d expected 1", ack_c[0]); else n_pass++;
        set_txn(0, 1, 0, 12'h020, 12'h000); set_txn(1, 1, 0, 12'h030, 12'h000);
        model_txn(); drive(8);
        n_total++; if (ack_c[1] !== 1) $display("FAIL tie2_ack1: got cycle %0d expected 1", ack_c[1]); else n_pass++;
        n_total++; if (ack_c[0] !== 4) $display("FAIL tie2_ack0: got cycle %0d expected 4", ack_c[0]); else n_pass++;
    endtask

    task automatic test_write_read();
        set_txn(0, 1, 1, 12'h010, 12'hABC); set_txn(1, 0, 0, 12'h000, 12'h000);
        model_txn(); drive(6);
        n_total++; if (ack_c[0] !== 1) $display("FAIL wr_ack: got cycle %0d expected 1", ack_c[0]); else n_pass++;
        n_total++; if (we_n !== 1) $display("FAIL wr_we_cycles: got %0d expected 1", we_n); else n_pass++;
        n_total++; if (ack_n[0] !== 1) $display("FAIL wr_ack_count: got %0d expected 1", ack_n[0]); else n_pass++;
        set_txn(0, 1, 0, 12'h010, 12'h000);
        model_txn(); drive(6);
        n_total++; if (rv_c[0] !== 2) $display("FAIL rd_rvalid: got cycle %0d expected 2", rv_c[0]); else n_pass++;
        n_total++; if (rd[0] !== 12'hABC) $display("FAIL rd_data: got %h expected abc", rd[0]); else n_pass++;
        n_total++; if (rv_n[0] !== 1) $display("FAIL rd_rvalid_count: got %0d expected 1", rv_n[0]); else n_pass++;
    endtask

    task automatic test_out_of_range();
        set_txn(0, 0, 0, 12'h000, 12'h000); set_txn(1, 1, 1, 12'h0FF, 12'h123);
        model_txn(); drive(6);
        n_total++; if (ack_c[1] !== 1) $display("FAIL oor_wr_ack: got cycle %0d expected 1", ack_c[1]); else n_pass++;
        n_total++; if (we_n !== 0) $display("FAIL oor_wr_we: got %0d cycles expected 0", we_n); else n_pass++;
        set_txn(1, 1, 0, 12'h0FF, 12'h000);
        model_txn(); drive(6);
        n_total++; if (rv_c[1] !== 2) $display("FAIL oor_rd_rvalid: got cycle %0d expected 2", rv_c[1]); else n_pass++;
        n_total++; if (rd[1] !== 12'h000) $display("FAIL oor_rd_data: got %h expected 000", rd[1]); else n_pass++;
        // Last implemented word behaves normally.
        set_txn(1, 1, 1, 12'h0FE, 12'h5A5);
        model_txn(); drive(6);
        n_total++; if (we_n !== 1) $display("FAIL top_wr_we: got %0d cycles expected 1", we_n); else n_pass++;
        set_txn(1, 1, 0, 12'h0FE, 12'h000);
        model_txn(); drive(6);
        n_total++; if (rd[1] !== 12'h5A5) $display("FAIL top_rd_data: got %h expected 5a5", rd[1]); else n_pass++;
    endtask

    task automatic test_withdraw();
        int a0 = 0;
        int w = 0;
        ifc.r1_req = 1'b1; ifc.r1_we = 1'b0; ifc.r1_addr = 12'h0FE; ifc.r1_wdata = 12'h000;
        tick();
        n_total++; if (ifc.r1_ack !== 1'b1) $display("FAIL wd_r1_ack: got %b expected 1", ifc.r1_ack); else n_pass++;
        exp_last = 1'b1;
        ifc.r1_req = 1'b0;
        ifc.r0_req = 1'b1; ifc.r0_we = 1'b1; ifc.r0_addr = 12'h040; ifc.r0_wdata = 12'h777;
        if (ifc.mem_write_enable) w++;
        tick();
        ifc.r0_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (ifc.r0_ack) a0++;
            if (ifc.mem_write_enable) w++;
            tick();
        end
        n_total++; if (a0 !== 0) $display("FAIL wd_r0_ack: got %0d acks expected 0", a0); else n_pass++;
        n_total++; if (w !== 0) $display("FAIL wd_mem_write: got %0d cycles expected 0", w); else n_pass++;
        set_txn(0, 1, 0, 12'h040, 12'h000); set_txn(1, 0, 0, 12'h000, 12'h000);
        model_txn(); drive(6);
        n_total++; if (rd[0] !== e_rd[0]) $display("FAIL wd_readback: got %h expected %h", rd[0], e_rd[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int rvs = 0;
        ifc.r0_req = 1'b1; ifc.r0_we = 1'b0; ifc.r0_addr = 12'h010; ifc.r0_wdata = 12'h000;
        tick();
        ifc.r0_req = 1'b0;
        tick();
        n_total++; if (ifc.r0_rvalid !== 1'b1 || ifc.r0_rdata !== ref_mem[12'h010])
            $display("FAIL rm_wait_rdata: got %b/%h expected 1/%h", ifc.r0_rvalid, ifc.r0_rdata, ref_mem[12'h010]); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_last = 1'b1;
        n_total++; if ({ifc.r0_rvalid, ifc.r0_ack, ifc.busy, ifc.mem_write_enable} !== 4'b0000)
            $display("FAIL rm_ctrl: got %b expected 0000", {ifc.r0_rvalid, ifc.r0_ack, ifc.busy, ifc.mem_write_enable}); else n_pass++;
        n_total++; if ({ifc.r0_rdata, ifc.mem_addr, ifc.mem_data_in} !== 36'h0)
            $display("FAIL rm_data: got %h expected 000000000", {ifc.r0_rdata, ifc.mem_addr, ifc.mem_data_in}); else n_pass++;
        // Reset while the read is in ISSUE: the read must never complete.
        ifc.r0_req = 1'b1;
        tick();
        ifc.r0_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (ifc.r0_rvalid) rvs++;
            tick();
        end
        n_total++; if (rvs !== 0) $display("FAIL rm_issue_rvalid: got %0d expected 0", rvs); else n_pass++;
        n_total++; if (ifc.busy !== 1'b0) $display("FAIL rm_issue_busy: got %b expected 0", ifc.busy); else n_pass++;
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        int a0 = 0;
        int a1 = 0;
        int w = 0;
        ifc.r1_lock = 1'b1;
        ifc.r0_req = 1'b1; ifc.r0_we = 1'b1; ifc.r0_addr = 12'h060; ifc.r0_wdata = 12'h333;
        ifc.r1_req = 1'b1; ifc.r1_we = 1'b1; ifc.r1_addr = 12'h050; ifc.r1_wdata = 12'h222;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ifc.r0_ack) a0++;
            if (ifc.r1_ack) a1++;
            if (ifc.mem_write_enable) w++;
        end
        n_total++; if (a1 !== 4) $display("FAIL lock_r1_grants: got %0d expected 4", a1); else n_pass++;
        n_total++; if (a0 !== 0) $display("FAIL lock_r0_grants: got %0d expected 0", a0); else n_pass++;
        n_total++; if (w !== 4) $display("FAIL lock_writes: got %0d expected 4", w); else n_pass++;
        ifc.r1_lock = 1'b0;
        tick();
        n_total++; if ({ifc.r0_ack, ifc.r1_ack} !== 2'b10) $display("FAIL unlock_grant: got %b expected 10", {ifc.r0_ack, ifc.r1_ack}); else n_pass++;
        ifc.r0_req = 1'b0; ifc.r1_req = 1'b0;
        tick(); tick();
        ref_mem[12'h050] = 12'h222;
        ref_mem[12'h060] = 12'h333;
        exp_last = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = int'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                logic [AW-1:0] a;
                case ($urandom_range(0, 3))
                    0: a = 12'h020 + 12'($urandom_range(0, 7));
                    1: a = 12'h0FE;
                    2: a = 12'h0FF + 12'($urandom_range(0, 1));
                    default: a = 12'($urandom);
                endcase
                set_txn(p, ((mode >> p) & 1) == 1, $urandom_range(0, 1) == 1, a, 12'($urandom));
            end
            model_txn();
            drive(8);
            for (int p = 0; p < 2; p++) begin
                n_total++; if (ack_c[p] !== e_ack[p]) $display("FAIL rnd%0d_ack%0d: got cycle %0d expected %0d", n, p, ack_c[p], e_ack[p]); else n_pass++;
                n_total++; if (ack_n[p] !== (t_en[p] ? 1 : 0)) $display("FAIL rnd%0d_nack%0d: got %0d expected %0d", n, p, ack_n[p], t_en[p] ? 1 : 0); else n_pass++;
                n_total++; if (rv_c[p] !== e_rv[p]) $display("FAIL rnd%0d_rv%0d: got cycle %0d expected %0d", n, p, rv_c[p], e_rv[p]); else n_pass++;
                if (t_en[p] && !t_we[p]) begin
                    n_total++; if (rd[p] !== e_rd[p]) $display("FAIL rnd%0d_rdata%0d: got %h expected %h", n, p, rd[p], e_rd[p]); else n_pass++;
                end
            end
            n_total++; if (we_n !== e_we) $display("FAIL rnd%0d_we: got %0d cycles expected %0d", n, we_n, e_we); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        ifc.r0_req = 1'b0; ifc.r0_we = 1'b0; ifc.r0_addr = '0; ifc.r0_wdata = '0;
        ifc.r1_req = 1'b0; ifc.r1_we = 1'b0; ifc.r1_addr = '0; ifc.r1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        ifc.r1_lock = 1'b0;
`endif
        exp_last = 1'b1;
        test_reset();
        test_contention();
        test_write_read();
        test_out_of_range();
        test_withdraw();
        test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
